button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The parameter list SHALL be: DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz).
REQ-002 The parameter list SHALL include: LONG_CYCLES, 100_000_000, cycles in the pressed state before a long-press event (1 s at 100 MHz); it SHALL be greater than DEBOUNCE_CYCLES.
REQ-003 The parameter list SHALL include: ACTIVE_LOW, 1, where 1 means the pin reads 0 when pressed.
REQ-004 The block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-005 Port sysClk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-006 Port rstN, input, 1 bit: asynchronous active-low reset.
REQ-007 Port btnIn, input, 1 bit: raw, asynchronous, bouncing push-button pin.
REQ-008 Port btnLevel, output, 1 bit: debounced level; 1 means pressed.
REQ-009 Port pressPulse, output, 1 bit: one-cycle strobe when an accepted press occurs.
REQ-010 Port releasePulse, output, 1 bit: one-cycle strobe when an accepted release occurs.
REQ-011 Port longPress, output, 1 bit: one-cycle strobe, at most once per accepted press.

Function
REQ-012 Normalisation: btnIn SHALL be inverted when ACTIVE_LOW=1, so that 1 means pressed, before the 2-flop synchronizer; the FSM SHALL use only the synchronizer output (s).
REQ-013 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 IDLE with s=1 SHALL transition to PRESS_WAIT, cnt=0; IDLE with s=0 SHALL stay in IDLE.
REQ-015 PRESS_WAIT with s=0 SHALL transition to IDLE, cnt=0, with no pulse.
REQ-016 PRESS_WAIT with s=1 and cnt<DEBOUNCE_CYCLES-1 SHALL increment cnt.
REQ-017 PRESS_WAIT with s=1 and cnt=DEBOUNCE_CYCLES-1 SHALL transition to PRESSED and assert pressPulse for that next cycle only; longCnt SHALL be set to 0 and longDone to 0.
REQ-018 PRESSED with s=0 SHALL transition to RELEASE_WAIT, cnt=0; RELEASE_WAIT SHALL mirror PRESS_WAIT with polarity swapped.
REQ-019 RELEASE_WAIT with s=1 SHALL return to PRESSED, cnt=0, with no pulse.
REQ-020 RELEASE_WAIT with s=0 and cnt=DEBOUNCE_CYCLES-1 SHALL transition to IDLE and assert releasePulse for one cycle.
REQ-021 Latency: with btnIn stable from its first sampling edge (edge 1), pressPulse and releasePulse SHALL be high in the cycle after edge DEBOUNCE_CYCLES+3.
REQ-022 btnLevel SHALL be registered, SHALL be 1 exactly while in PRESSED or RELEASE_WAIT, and SHALL rise on the same edge pressPulse rises.
REQ-023 longCnt SHALL count every cycle in PRESSED or RELEASE_WAIT, so that release bounces do not restart it.
REQ-024 When longCnt=LONG_CYCLES-1 and longDone=0, longPress SHALL pulse for one cycle and longDone SHALL be set to 1.
REQ-025 longCnt SHALL saturate, with no wrap and no second longPress.
REQ-026 A release accepted before the long threshold SHALL produce no longPress.
REQ-027 If a longPress and releasePulse condition coincide, both SHALL be emitted on the same cycle.
REQ-028 cnt width SHALL be clog2(DEBOUNCE_CYCLES), and longCnt width SHALL be clog2(LONG_CYCLES).
REQ-029 No counter SHALL ever wrap.
REQ-030 pressPulse and releasePulse SHALL never be high on the same cycle.

Reset
REQ-031 rstN low SHALL immediately force: state IDLE, cnt=0, longCnt=0, longDone=0, both synchronizer flops=0 (released), and btnLevel, pressPulse, releasePulse and longPress all 0.
REQ-032 Reset asserted mid-press SHALL drop btnLevel without emitting releasePulse.
REQ-033 A button held through reset deassertion SHALL be debounced normally and SHALL yield pressPulse per REQ-021.

Structure
REQ-034 State encodings and the default timing constants SHALL reside in shared package ui_pkg, for reuse by future LED/user-I/O blocks.
REQ-035 The synchronizer SHALL be sub-module sync_2ff (1-bit, async active-low reset, reset value parameterised).
REQ-036 The FSM and counters SHALL live in button_debounce.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1)
REQ-037 btnIn held 0 from edge 1 -> pressPulse high only after edge 7; btnLevel=1 from edge 7.
REQ-038 While released, btnIn pulses low for 3 cycles then returns high -> no pressPulse, btnLevel stays 0.
REQ-039 Press accepted, then btnIn glitches high for 2 cycles -> no releasePulse, btnLevel stays 1, and longPress still fires 20 cycles after pressPulse.
REQ-040 Press held for 60 cycles -> exactly one longPress; release -> one releasePulse 7 edges after btnIn returns high.
REQ-041 rstN pulsed low while in PRESSED with btnIn=0 -> all outputs 0 immediately, no releasePulse; after rstN rises, pressPulse appears after edge 7.
REQ-042 Press held for 10 cycles then released -> pressPulse and releasePulse each exactly once, and no longPress.

Source files
------------

// File: rtl/ui_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ui_pkg
// Purpose  : Shared definitions for user-I/O blocks (buttons, LEDs, ...).
//            Holds the debouncer state encoding, default timing constants
//            and a counter-width helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package ui_pkg;

  // Default timing at a 100 MHz system clock.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms
  localparam int unsigned DEFAULT_LONG_CYCLES     = 100_000_000; // 1 s

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // clog2 with a floor of one bit so a count of 1 still gives a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : ui_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : 1-bit two-flop synchronizer for an asynchronous input.
// Ports    : clk    - destination clock
//            rst_n  - asynchronous active-low reset (both flops -> RESET_VAL)
//            d      - asynchronous input
//            q      - synchronized output
// Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Debounces a raw push-button pin and produces a clean level plus
//            press, release and long-press strobes.
// Ports    : sysClk       - system clock, rising edge
//            rstN         - asynchronous active-low reset
//            btnIn        - raw asynchronous, bouncing button pin
//            btnLevel     - debounced level, 1 = pressed
//            pressPulse   - one-cycle strobe on accepted press
//            releasePulse - one-cycle strobe on accepted release
//            longPress    - one-cycle strobe, at most once per accepted press
// Revision : 1.0  initial release
// ============================================================================
module button_debounce
  import ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic sysClk,
  input  logic rstN,
  input  logic btnIn,
  output logic btnLevel,
  output logic pressPulse,
  output logic releasePulse,
  output logic longPress
);

  localparam int unsigned CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned LONG_W = cnt_width(LONG_CYCLES);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  // Normalise so that 1 always means pressed before crossing into sysClk.
  logic btn_norm;
  logic s;

  assign btn_norm = ACTIVE_LOW ? ~btnIn : btnIn;

  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk   (sysClk),
    .rst_n (rstN),
    .d     (btn_norm),
    .q     (s)
  );

  btn_state_e        state_q,         state_d;
  logic [CNT_W-1:0]  cnt_q,           cnt_d;
  logic [LONG_W-1:0] long_cnt_q,      long_cnt_d;
  logic              long_done_q,     long_done_d;
  logic              btn_level_q,     btn_level_d;
  logic              press_pulse_q,   press_pulse_d;
  logic              release_pulse_q, release_pulse_d;
  logic              long_press_q,    long_press_d;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    long_cnt_d      = long_cnt_q;
    long_done_d     = long_done_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_press_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = PRESSED;
          cnt_d         = '0;
          press_pulse_d = 1'b1;
          long_cnt_d    = '0;
          long_done_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end

      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d         = IDLE;
          cnt_d           = '0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // The hold timer runs through release bounces too, so a brief glitch
    // while held does not restart it. It saturates at the threshold and
    // long_done blocks a second strobe for the same press.
    if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
      if (long_cnt_q == LONG_LAST) begin
        if (!long_done_q) begin
          long_press_d = 1'b1;
          long_done_d  = 1'b1;
        end
      end else begin
        long_cnt_d = long_cnt_q + 1'b1;
      end
    end

    // Registered from the next state so the level rises with pressPulse.
    btn_level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge sysClk or negedge rstN) begin
    if (!rstN) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      long_cnt_q      <= '0;
      long_done_q     <= 1'b0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_press_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      long_cnt_q      <= long_cnt_d;
      long_done_q     <= long_done_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_press_q    <= long_press_d;
    end
  end

  assign btnLevel     = btn_level_q;
  assign pressPulse   = press_pulse_q;
  assign releasePulse = release_pulse_q;
  assign longPress    = long_press_q;

endmodule : button_debounce
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce
// Purpose  : Self-checking bench for button_debounce with DEBOUNCE_CYCLES=4,
//            LONG_CYCLES=20, ACTIVE_LOW=1. A run-length model of the
//            debouncing rules is compared against the DUT every cycle, and
//            directed scenarios pin event timing with literal edge numbers.
// Revision : 1.0  initial release
// ============================================================================
module tb_button_debounce;

  localparam int D = 4;
  localparam int L = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn   = 1'b1;
  logic btn_level, press_pulse, release_pulse, long_press;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .sysClk       (clk),
    .rstN         (rst_n),
    .btnIn        (btn),
    .btnLevel     (btn_level),
    .pressPulse   (press_pulse),
    .releasePulse (release_pulse),
    .longPress    (long_press)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The synchronized pin is the raw pressed level delayed two edges. An
  // accepted change needs D+1 consecutive synchronized samples that differ
  // from the current debounced level. A long press fires once when the
  // accepted level has been held for L edges.
  logic m_p1 = 1'b0, m_s = 1'b0, m_level = 1'b0;
  logic m_press = 1'b0, m_rel = 1'b0, m_long = 1'b0, m_done = 1'b0;
  int   m_run = 0, m_age = 0, edge_n = 0;

  always @(posedge clk or negedge rst_n) begin : model
    logic s_use, lvl, done, pp, rp, lp;
    int   run, age;
    if (!rst_n) begin
      m_p1 <= 1'b0; m_s <= 1'b0; m_level <= 1'b0;
      m_press <= 1'b0; m_rel <= 1'b0; m_long <= 1'b0; m_done <= 1'b0;
      m_run <= 0; m_age <= 0; edge_n <= 0;
    end else begin
      s_use = m_s; lvl = m_level; run = m_run; age = m_age; done = m_done;
      pp = 1'b0; rp = 1'b0; lp = 1'b0;
      if (lvl) begin
        if (age < L) age++;
        if (age == L && !done) begin
          lp = 1'b1;
          done = 1'b1;
        end
      end
      if (s_use != lvl) begin
        run++;
        if (run == D + 1) begin
          lvl = ~lvl;
          run = 0;
          if (lvl) begin
            pp = 1'b1; age = 0; done = 1'b0;
          end else begin
            rp = 1'b1;
          end
        end
      end else begin
        run = 0;
      end
      m_level <= lvl; m_run <= run; m_age <= age; m_done <= done;
      m_press <= pp; m_rel <= rp; m_long <= lp;
      m_s <= m_p1; m_p1 <= ~btn;
      edge_n <= edge_n + 1;
    end
  end

  // ---------------- per-cycle compare + event log ----------------
  int press_cnt = 0, rel_cnt = 0, long_cnt = 0;
  int press_edge = -1, rel_edge = -1, long_edge = -1;

  always @(negedge clk) begin
    check("level", btn_level, m_level);
    check("press_pulse", press_pulse, m_press);
    check("release_pulse", release_pulse, m_rel);
    check("long_press", long_press, m_long);
    if (press_pulse && release_pulse)
      check("press_and_release_same_cycle", 1, 0);
    if (press_pulse)   begin press_cnt++; press_edge = edge_n; end
    if (release_pulse) begin rel_cnt++;   rel_edge   = edge_n; end
    if (long_press)    begin long_cnt++;  long_edge  = edge_n; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // which: 0 = press, 1 = release, 2 = long press
  function automatic int get_cnt(input int which);
    case (which)
      0:       return press_cnt;
      1:       return rel_cnt;
      default: return long_cnt;
    endcase
  endfunction

  task automatic wait_evt(input string name, input int which, input int target, input int bound);
    int n = 0;
    while (get_cnt(which) < target && n < bound) begin
      step(1);
      n++;
    end
    check(name, get_cnt(which), target);
  endtask

  int p0, r0, l0, pe, rs;

  initial begin
    // Reset state
    rst_n = 1'b0;
    btn   = 1'b1;
    step(3);
    check("rst_level", btn_level, 0);
    check("rst_press", press_pulse, 0);
    check("rst_release", release_pulse, 0);
    check("rst_long", long_press, 0);

    // Press held from edge 1: accepted at edge D+3 = 7
    rst_n = 1'b1;
    btn   = 1'b0;
    wait_evt("press_a_seen", 0, 1, 40);
    check("press_a_edge", press_edge, 7);
    check("press_a_level", btn_level, 1);

    // 2-cycle release glitch while held: no release, long press 20 later
    step(2);
    btn = 1'b1;
    step(2);
    btn = 1'b0;
    wait_evt("long_a_seen", 2, 1, 40);
    check("long_a_edge", long_edge, 27);
    check("glitch_no_release", rel_cnt, 0);
    check("glitch_level", btn_level, 1);

    // Keep holding well past the threshold: still only one long press
    step(40);
    check("long_once", long_cnt, 1);

    // Release: accepted 7 edges after the pin returns high
    btn = 1'b1;
    rs  = edge_n + 1;
    wait_evt("release_a_seen", 1, 1, 40);
    check("release_a_edge", rel_edge - rs, 6);
    check("release_a_level", btn_level, 0);
    check("release_a_no_long", long_cnt, 1);

    // 3-cycle press glitch while released: rejected
    btn = 1'b0;
    step(3);
    btn = 1'b1;
    step(20);
    check("glitch_no_press", press_cnt, 1);
    check("glitch_rel_level", btn_level, 0);

    // Short press (10 cycles): one press, one release, no long press
    p0 = press_cnt; r0 = rel_cnt; l0 = long_cnt;
    btn = 1'b0;
    step(10);
    btn = 1'b1;
    step(30);
    check("short_press_cnt", press_cnt - p0, 1);
    check("short_release_cnt", rel_cnt - r0, 1);
    check("short_no_long", long_cnt - l0, 0);

    // Release accepted on exactly the long-press edge: both strobes together
    p0 = press_cnt; r0 = rel_cnt; l0 = long_cnt;
    btn = 1'b0;
    wait_evt("coinc_press_seen", 0, p0 + 1, 40);
    pe = press_edge;
    step(13);
    btn = 1'b1;
    wait_evt("coinc_release_seen", 1, r0 + 1, 40);
    check("coinc_release_edge", rel_edge - pe, 20);
    check("coinc_long_edge", long_edge - pe, 20);
    check("coinc_long_cnt", long_cnt - l0, 1);
    step(5);

    // Reset mid-press: outputs drop at once, no release strobe
    p0 = press_cnt;
    btn = 1'b0;
    wait_evt("rst_press_seen", 0, p0 + 1, 40);
    step(3);
    r0 = rel_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_level", btn_level, 0);
    check("midrst_press", press_pulse, 0);
    check("midrst_release", release_pulse, 0);
    check("midrst_long", long_press, 0);
    step(2);
    check("midrst_no_release", rel_cnt, r0);

    // Button held through reset release: debounced again from edge 1
    p0 = press_cnt;
    rst_n = 1'b1;
    wait_evt("post_rst_press_seen", 0, p0 + 1, 40);
    check("post_rst_press_edge", press_edge, 7);
    btn = 1'b1;
    step(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_button_debounce
`default_nettype wire
